// File: rtl/n64_pi_pkg.sv
// Shared types and address helper for the N64 PI cartridge front end.
package n64_pi_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR_L,
        S_DATA
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [15:0] wdata;
    } req_t;

    localparam logic [31:0] ADDR_STEP = 32'd2;

    // Word-address increment; the carry out of bit 31 is dropped so the bus wraps.
    function automatic logic [31:0] addr_next(input logic [31:0] a);
        logic [31:0] s;
        s = a + ADDR_STEP;
        return {s[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/n64_pi_sync.sv
// Multi-bit flop synchronizer with edge detection on the final stage.
module n64_pi_sync #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] chain [STAGES];
    logic [WIDTH-1:0] last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
            last <= RESET_VAL;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            last <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~last;
    assign fall  = ~level & last;

endmodule

// File: rtl/n64_pi_frontend.sv
// N64 PI cartridge front end: strobe sync, address latch, burst data phase and a
// single-word request/ack memory port with one-word read prefetch.
//   state    | meaning
//   S_IDLE   | waiting for ALEH fall while ALEL is high
//   S_ADDR_L | high half latched, waiting for ALEL fall
//   S_DATA   | burst data phase, READ/WRITE strobes serviced
module n64_pi_frontend
    import n64_pi_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] IDLE_DATA   = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_n64_reset,
    input  logic        i_alel,
    input  logic        i_aleh,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [15:0] i_ad,
    output logic [15:0] o_ad,
    output logic        o_ad_oe,
    output logic        o_request,
    output logic        o_write,
    output logic [31:0] o_address,
    output logic [15:0] o_wdata,
    input  logic        i_ack,
    input  logic [15:0] i_rdata,
    output logic        o_busy,
    output logic        o_underrun,
    output logic        o_overrun,
    input  logic        i_status_clear
);

    logic [4:0]  lvl, rise, fall;
    logic [15:0] ad_pipe [SYNC_STAGES+1];
    logic [15:0] ad_dly;
    logic        unused_sync;

    n64_pi_sync #(.WIDTH(5), .STAGES(SYNC_STAGES)) u_sync (
        .clk  (i_clk),
        .rst  (i_reset),
        .din  ({i_n64_reset, i_write, i_read, i_aleh, i_alel}),
        .level(lvl),
        .rise (rise),
        .fall (fall)
    );

    assign unused_sync = ^{lvl[3:1], rise[4], rise[1], fall[4:3]};

    // One stage deeper than the strobes so AD lines up with the detected edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i <= SYNC_STAGES; i++) ad_pipe[i] <= '0;
        end else begin
            ad_pipe[0] <= i_ad;
            for (int i = 1; i <= SYNC_STAGES; i++) ad_pipe[i] <= ad_pipe[i-1];
        end
    end
    assign ad_dly = ad_pipe[SYNC_STAGES];

    state_t      state, state_n;
    req_t        req, req_n;
    logic [31:0] addr, addr_n;
    logic [15:0] pf_buf, pf_buf_n, ad_n;
    logic        pf_valid, pf_valid_n, pf_pend, pf_pend_n;
    logic        discard, discard_n, fill, fill_n;
    logic        request_n, oe_n, underrun_n, overrun_n;
    logic        want_pf, wr_issue, kill_rd, flush, free, rd_done, pf_req;

    assign free    = ~o_request | i_ack;
    assign rd_done = o_request & i_ack & ~req.write & ~discard;

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        req_n      = req;
        request_n  = o_request;
        pf_valid_n = pf_valid;
        pf_pend_n  = pf_pend;
        pf_buf_n   = pf_buf;
        discard_n  = discard;
        fill_n     = fill;
        ad_n       = o_ad;
        oe_n       = o_ad_oe;
        underrun_n = o_underrun & ~i_status_clear;
        overrun_n  = o_overrun & ~i_status_clear;
        want_pf    = 1'b0;
        wr_issue   = 1'b0;
        kill_rd    = 1'b0;
        flush      = 1'b0;
        pf_req     = 1'b0;

        if (rd_done) begin
            pf_valid_n = 1'b1;
            pf_buf_n   = i_rdata;
            if (fill) begin
                ad_n   = i_rdata;
                fill_n = 1'b0;
            end
        end
        if (o_request && i_ack) begin
            request_n = 1'b0;
            discard_n = 1'b0;
        end

        if (!lvl[4]) begin
            flush = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fall[1] && lvl[0]) begin
                        addr_n[31:16] = ad_dly;
                        state_n       = S_ADDR_L;
                    end
                end
                S_ADDR_L: begin
                    if (rise[0]) begin
                        flush = 1'b1;
                    end else if (fall[0]) begin
                        addr_n[15:0] = {ad_dly[15:1], 1'b0};
                        want_pf      = 1'b1;
                        state_n      = S_DATA;
                    end
                end
                S_DATA: begin
                    if (rise[0]) begin
                        flush = 1'b1;
                    end else if (rise[3]) begin
                        if (fall[2] || rise[2] || !free) overrun_n = 1'b1;
                        wr_issue = free;
                        addr_n   = addr_next(addr);
                    end else if (fall[2]) begin
                        oe_n = 1'b1;
                        if (pf_valid || rd_done) begin
                            ad_n = pf_valid ? pf_buf : i_rdata;
                        end else begin
                            ad_n       = IDLE_DATA;
                            underrun_n = 1'b1;
                            fill_n     = 1'b1;
                        end
                    end else if (rise[2]) begin
                        oe_n       = 1'b0;
                        addr_n     = addr_next(addr);
                        pf_valid_n = 1'b0;
                        fill_n     = 1'b0;
                        kill_rd    = 1'b1;
                        want_pf    = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        if (flush) begin
            state_n    = S_IDLE;
            oe_n       = 1'b0;
            pf_valid_n = 1'b0;
            pf_pend_n  = 1'b0;
            fill_n     = 1'b0;
            kill_rd    = 1'b1;
        end
        // A read still in flight when its data stops being wanted lands in the void.
        if (kill_rd && o_request && !i_ack && !req.write) discard_n = 1'b1;

        pf_req = want_pf | pf_pend_n;
        if (wr_issue) begin
            request_n     = 1'b1;
            req_n.write   = 1'b1;
            req_n.address = addr;
            req_n.wdata   = ad_dly;
            pf_pend_n     = pf_req;
        end else if (pf_req) begin
            if (free) begin
                request_n     = 1'b1;
                req_n.write   = 1'b0;
                req_n.address = addr_n;
                pf_pend_n     = 1'b0;
            end else begin
                pf_pend_n = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            req        <= '0;
            o_request  <= 1'b0;
            pf_valid   <= 1'b0;
            pf_pend    <= 1'b0;
            pf_buf     <= '0;
            discard    <= 1'b0;
            fill       <= 1'b0;
            o_ad       <= IDLE_DATA;
            o_ad_oe    <= 1'b0;
            o_underrun <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            req        <= req_n;
            o_request  <= request_n;
            pf_valid   <= pf_valid_n;
            pf_pend    <= pf_pend_n;
            pf_buf     <= pf_buf_n;
            discard    <= discard_n;
            fill       <= fill_n;
            o_ad       <= ad_n;
            o_ad_oe    <= oe_n;
            o_underrun <= underrun_n;
            o_overrun  <= overrun_n;
        end
    end

    assign o_write   = req.write;
    assign o_address = req.address;
    assign o_wdata   = req.wdata;
    assign o_busy    = (state != S_IDLE);

endmodule

// File: doc/n64_pi_frontend.md
Name: n64_pi_frontend

Overview:
Cartridge-side N64 Parallel Interface (PI) front end, sitting directly downstream of the top-level PI pins.
- Synchronizes ALEL/ALEH/READ/WRITE into the system clock domain.
- Latches the 32-bit bus address and runs the 16-bit burst data phase.
- Converts PI cycles into single-word read/write requests on a simple request/ack memory port, with one-word read prefetch.
- The top level owns the AD tristate; this block only supplies output data and output enable.

Parameters:
SYNC_STAGES, 2, synchronizer flop count for strobes, n64_reset and the AD delay line; legal values 2..3
IDLE_DATA, 16'hFFFF, value driven on AD when no valid read data exists

Ports:
i_clk  in  1  system clock; all logic is on its rising edge
i_reset  in  1  asynchronous active-high reset
i_n64_reset  in  1  N64 reset, active low, asynchronous to i_clk
i_alel  in  1  PI ALE_L, asynchronous
i_aleh  in  1  PI ALE_H, asynchronous
i_read  in  1  PI READ strobe, active low, asynchronous
i_write  in  1  PI WRITE strobe, active low, asynchronous
i_ad  in  16  PI AD bus input
o_ad  out  16  PI AD bus output data
o_ad_oe  out  1  AD output enable
o_request  out  1  memory request; held high until i_ack
o_write  out  1  request type: 1 = write, 0 = read; stable while o_request is high
o_address  out  32  request byte address; bit 0 is always 0
o_wdata  out  16  write data; stable while o_request is high
i_ack  in  1  one-cycle acknowledge; completes the current request
i_rdata  in  16  read data, valid in the i_ack cycle of a read
o_busy  out  1  high in any state other than S_IDLE
o_underrun  out  1  sticky: a read strobe arrived before prefetch data was valid
o_overrun  out  1  sticky: a write strobe arrived while a request was still pending
i_status_clear  in  1  clears both sticky flags; a set event in the same cycle wins

Behaviour:
Reset values, all outputs:
- o_ad = IDLE_DATA; o_address = 0; o_wdata = 0.
- o_ad_oe, o_request, o_write, o_busy, o_underrun, o_overrun = 0.
- Internal state: S_IDLE; prefetch-valid = 0.

Synchronization and edge detection:
- Each strobe and i_n64_reset passes through a SYNC_STAGES flop synchronizer.
- Edges are detected on the last synchronizer stage against one further flop.
- i_ad passes through a delay line of depth SYNC_STAGES+1, so AD is sampled aligned with the detected edge.

State machine (n64_pi_pkg::state_t):
- S_IDLE: when ALEH falls while ALEL is high, addr[31:16] <= delayed AD; go to S_ADDR_L.
- S_ADDR_L: when ALEL falls, addr[15:0] <= {AD[15:1], 1'b0}; issue a read prefetch at addr; go to S_DATA.
- S_DATA, READ falling edge:
  - o_ad_oe = 1 on the next cycle.
  - If prefetch-valid: o_ad = prefetch buffer.
  - Else: o_ad = IDLE_DATA, set o_underrun, and o_ad updates in the cycle after i_ack.
- S_DATA, READ rising edge: o_ad_oe = 0; addr += 2; prefetch-valid = 0; issue a read prefetch.
- S_DATA, WRITE rising edge:
  - If no request is pending: o_wdata <= AD; issue a write at addr; addr += 2.
  - Else: set o_overrun, drop the data, and still do addr += 2.
- From S_ADDR_L or S_DATA, ALEL rising: go to S_IDLE; o_ad_oe = 0; prefetch-valid = 0.

Request rules:
- A new request asserts o_request on the cycle after the triggering event.
- o_address, o_write and o_wdata are frozen while o_request is high.
- A request is never withdrawn. It always completes on i_ack, including across an abort or a return to S_IDLE.
- If a prefetch is wanted while a request is pending, it is queued as one pending-prefetch bit and issued the cycle after that ack.
- Read data acked after an abort is discarded and does not set prefetch-valid.

Address arithmetic:
- Increment operates on addr[31:1] modulo 2^31, so 0xFFFF_FFFE + 2 wraps to 0x0000_0000.
- o_address tracks the request address, not the live counter.

Synchronized i_n64_reset low (abort):
- Immediate return to S_IDLE; o_ad_oe = 0.
- Pending-prefetch bit and prefetch-valid cleared.
- Any in-flight request still completes normally.

Simultaneous events:
- ALEL rising has priority over READ/WRITE edges in the same cycle.
- READ and WRITE edges in the same cycle: the write is processed, the read is ignored, and o_overrun is set.

Asynchronous i_reset mid-operation: forces all reset values at once, including dropping o_request.

Decomposition:
- n64_pi_pkg:
  - state_t enum (S_IDLE, S_ADDR_L, S_DATA)
  - req_t struct {write, address[31:0], wdata[15:0]}
  - ADDR_STEP = 2
- One natural sub-module, n64_pi_sync: a parameterized multi-bit synchronizer plus edge detector with outputs level, rise and fall. It is instantiated for the four strobes and n64_reset.

Test Plan:
1. Address cycle with AD = 0x1000 at ALEH fall and 0x0203 at ALEL fall, then ack with rdata 0xBEEF -> o_address = 0x1000_0202 read request; first READ pulse drives AD = 0xBEEF with o_ad_oe = 1.
2. Four READ pulses, ack 2 cycles after each request -> requests at 0x...0202, 0204, 0206, 0208, 020A; AD sequence matches the rdata given; o_underrun = 0.
3. READ falling edge with ack delayed 20 cycles -> AD = 0xFFFF first, then rdata; o_underrun = 1; i_status_clear returns it to 0.
4. Two WRITE pulses of 0x1234 and 0x5678 with the ack held off until after the second pulse -> a single write request (0x1234); o_overrun = 1; next address advanced by 4.
5. Start address 0xFFFF_FFFE plus one READ pulse -> next prefetch at 0x0000_0000.
6. Abort: i_n64_reset low mid-burst with a request pending -> S_IDLE, o_ad_oe = 0, o_request held until ack, then no further request; async i_reset clears o_request immediately.
